bram_target: RTL
================

Name: bram_target

Overview:
- Memory-side responder for the CPU request interface. Accepts single-beat and 4-beat line requests from the 68040 bus front end and serves them from an on-chip synchronous block RAM.
- Reads are returned on the din/din_valid/din_ack stream. Writes are taken from the dout/dout_valid stream and applied with byte masks.
- Sits directly opposite the CPU bus interface on the SoC request/data channels. It is used as boot ROM/RAM at address window BASE.

Parameters:
- BASE, 16'h4000: required value of req_addr[31:16] for a hit.
- AW, 12: RAM word-address width (depth 2^AW x 32 bit); uses req_addr[AW+1:2].
- WAIT_STATES, 0: extra cycles inserted before each read beat (range 0-15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid  in  1  one-cycle request strobe
- req_ready  out  1  high while write-data phase accepts dout beats
- req_len  in  3  beats: 4 = line burst, any other value = 1 beat
- req_mask  in  4  byte enables; bit3 = bits 31:24 (byte offset 0, big-endian)
- req_addr  in  32  byte address
- req_we  in  1  1 = write, 0 = read
- dout_valid  in  1  one-cycle write-data strobe
- dout  in  32  write data
- din_valid  out  1  read data available (level, held until acked)
- din  out  32  read data
- din_ack  in  1  one-cycle strobe consuming current din beat
- err  out  1  one-cycle pulse on decode miss or request while busy

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=0; din_valid=0; din=0; err=0; beat counter=0. RAM contents are not cleared.
- States: IDLE, RD_WAIT, RD_VALID, WR.
- IDLE: on req_valid, capture addr, mask, we and len (nlen = 4 if req_len==4, else 1), and set beat=0.
  - Hit is req_addr[31:16]==BASE.
  - req_we=1 goes to WR.
  - req_we=0 goes to RD_WAIT with wait counter = WAIT_STATES.
- Beat address: word index = {addr[AW+1:4], (addr[3:2]+beat) mod 4}. Line bursts wrap within the 16-byte line; single beats use addr[AW+1:2] directly.
- Masks: line bursts force mask=4'b1111; single beats use the captured mask.
- RD_WAIT: decrement the wait counter each cycle. When it reaches 0, issue the synchronous RAM read. On the next edge, register the RAM output (or 32'hFFFF_FFFF on a miss) into din, set din_valid=1, and go to RD_VALID.
- Read latency with WAIT_STATES=0: din_valid rises 2 cycles after the edge sampling req_valid (or din_ack).
- RD_VALID: din and din_valid are held stable until din_ack. On din_ack:
  - din_valid goes to 0 on the same edge.
  - If beat==nlen-1, go to IDLE.
  - Otherwise beat+1, go to RD_WAIT with counter reloaded.
- din_ack while din_valid=0 is ignored.
- WR: req_ready=1. Each dout_valid writes dout to the beat address with the byte enables.
  - On a miss, the write is dropped but the beat still counts.
  - After beat nlen-1 is written, req_ready=0 on the next edge and state goes to IDLE.
  - Otherwise beat+1.
- Mask lane mapping: mask[3] -> dout[31:24], mask[2] -> [23:16], mask[1] -> [15:8], mask[0] -> [7:0].
- Misses: err pulses for one cycle in the cycle after the request is captured. The handshake always completes so the CPU never hangs.
- req_valid while not IDLE: the request is ignored, err pulses, and the current transaction is unaffected.
- dout_valid outside WR: ignored, no err.
- Reset mid-transaction: immediate return to IDLE with din_valid=0 and req_ready=0. A RAM write issued in the same cycle as reset assertion need not complete.
- Throughput: at most one RAM access per cycle. No read-during-write hazard, since reads and writes never overlap.

Test Plan:
- Single-long write, then read. Write 0x40000010 mask 1111, dout=0xDEADBEEF; then read 0x40000010 -> din=0xDEADBEEF with din_valid 2 cycles after req_valid; err stays 0.
- Byte masks. Preload word 0x40000020 with 0x11223344; write mask 0100, dout=0xAABBCCDD; read back -> 0x11BB3344. Then write mask 0011, dout=0x0000EEFF -> 0x11BBEEFF.
- Wrapped line read. Preload 0x40000030..3C with 0xA0,0xA1,0xA2,0xA3; read req_len=4 at 0x40000038 -> beats 0xA2,0xA3,0xA0,0xA1, each after din_ack. Delaying an ack by 5 cycles must hold din constant; returns to IDLE after the 4th ack.
- Line write plus wait states. With WAIT_STATES=3, a line write at 0x40000040 of 1,2,3,4 (dout_valid spaced 4 cycles apart) completes with req_ready dropping after beat 4. A read-back shows din_valid 5 cycles after each ack.
- Decode miss. Read 0x80000000 -> din=0xFFFFFFFF plus a one-cycle err pulse. Write 0x80000000 of 0x12345678 -> accepted, err pulse, and 0x40000000 is unchanged.
- Busy and reset. A second req_valid during RD_VALID -> err pulse, first read unaffected. Asserting rst_i while din_valid=1 -> din_valid and req_ready go low asynchronously; a subsequent read of 0x40000010 still returns 0xDEADBEEF.

Source files
------------

// File: rtl/bram_target.sv
// bram_target: memory-side responder for the CPU request interface.
// Serves single-beat and 4-beat wrapped line requests from an on-chip
// synchronous block RAM mapped at the 64 KiB window BASE. Reads return on the
// din/din_valid/din_ack stream; writes arrive on dout/dout_valid with byte
// enables. Misses and requests while busy pulse err, but every accepted
// transaction still completes its handshake so the CPU never hangs.
`timescale 1ns/1ps

module bram_target #(
   parameter logic [15:0] BASE        = 16'h4000,
   parameter int          AW          = 12,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_len,
   input  logic [3:0]  req_mask,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic        dout_valid,
   input  logic [31:0] dout,
   output logic        din_valid,
   output logic [31:0] din,
   input  logic        din_ack,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_VALID = 2'd2,
      WR       = 2'd3
   } state_t;

   // Transaction context captured when a request is accepted.
   state_t          state_q,     state_d;
   logic [AW-1:0]   idx_q,       idx_d;       // word index of the requested address
   logic [3:0]      mask_q,      mask_d;
   logic            line_q,      line_d;      // 1 = 4-beat wrapped line burst
   logic            hit_q,       hit_d;       // address fell inside the BASE window
   logic [1:0]      beat_q,      beat_d;
   logic [3:0]      wait_q,      wait_d;
   logic            rd_pend_q,   rd_pend_d;   // RAM read issued, data arrives next edge

   // Registered outputs.
   logic            req_ready_q, req_ready_d;
   logic            din_valid_q, din_valid_d;
   logic [31:0]     din_q,       din_d;
   logic            err_q,       err_d;

   // RAM interface.
   logic [31:0]     mem [0:(1<<AW)-1];
   logic [31:0]     ram_rdata_q;
   logic            ram_we;
   logic            ram_re;
   logic [AW-1:0]   beat_idx;
   logic [1:0]      lane_sum;
   logic [3:0]      beat_be;
   logic            last_beat;

   // Byte-offset bits and the upper window bits below BASE do not select RAM words.
   logic            unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[15:AW+2], req_addr[1:0]};

   // Line bursts wrap inside the 16-byte line: only the low two word bits advance.
   assign lane_sum  = idx_q[1:0] + beat_q;
   assign beat_idx  = {idx_q[AW-1:2], lane_sum};
   assign beat_be   = line_q ? 4'b1111 : mask_q;
   assign last_beat = !line_q || (beat_q == 2'd3);

   assign req_ready = req_ready_q;
   assign din_valid = din_valid_q;
   assign din       = din_q;
   assign err       = err_q;

   // State and output registers; returns to IDLE immediately on reset.
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         mask_q      <= '0;
         line_q      <= 1'b0;
         hit_q       <= 1'b0;
         beat_q      <= '0;
         wait_q      <= '0;
         rd_pend_q   <= 1'b0;
         req_ready_q <= 1'b0;
         din_valid_q <= 1'b0;
         din_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         line_q      <= line_d;
         hit_q       <= hit_d;
         beat_q      <= beat_d;
         wait_q      <= wait_d;
         rd_pend_q   <= rd_pend_d;
         req_ready_q <= req_ready_d;
         din_valid_q <= din_valid_d;
         din_q       <= din_d;
         err_q       <= err_d;
      end
   end

   // Next-state and RAM strobes for the request/read/write sequencing.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mask_d      = mask_q;
      line_d      = line_q;
      hit_d       = hit_q;
      beat_d      = beat_q;
      wait_d      = wait_q;
      rd_pend_d   = rd_pend_q;
      req_ready_d = req_ready_q;
      din_valid_d = din_valid_q;
      din_d       = din_q;
      err_d       = 1'b0;
      ram_we      = 1'b0;
      ram_re      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               idx_d  = req_addr[AW+1:2];
               mask_d = req_mask;
               line_d = (req_len == 3'd4);
               hit_d  = (req_addr[31:16] == BASE);
               beat_d = 2'd0;
               err_d  = (req_addr[31:16] != BASE);
               if (req_we) begin
                  state_d     = WR;
                  req_ready_d = 1'b1;
               end else begin
                  state_d   = RD_WAIT;
                  wait_d    = 4'(WAIT_STATES);
                  rd_pend_d = 1'b0;
               end
            end
         end

         RD_WAIT: begin
            if (rd_pend_q) begin
               // A miss returns all ones instead of RAM contents.
               din_d       = hit_q ? ram_rdata_q : 32'hFFFF_FFFF;
               din_valid_d = 1'b1;
               rd_pend_d   = 1'b0;
               state_d     = RD_VALID;
            end else if (wait_q == 4'd0) begin
               ram_re    = hit_q;
               rd_pend_d = 1'b1;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end

         RD_VALID: begin
            if (din_ack) begin
               din_valid_d = 1'b0;
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  beat_d    = beat_q + 2'd1;
                  wait_d    = 4'(WAIT_STATES);
                  rd_pend_d = 1'b0;
                  state_d   = RD_WAIT;
               end
            end
         end

         WR: begin
            if (dout_valid) begin
               // A miss still consumes the beat so the write handshake completes.
               ram_we = hit_q;
               if (last_beat) begin
                  req_ready_d = 1'b0;
                  state_d     = IDLE;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // A request arriving mid-transaction is dropped and flagged.
      if (req_valid && (state_q != IDLE)) begin
         err_d = 1'b1;
      end
   end

   // Synchronous single-port RAM with per-byte write enables.
   // NOTE: the array and its read register have no reset; clearing a block RAM
   // is not possible in one cycle and contents must survive a CPU reset.
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (beat_be[i]) begin
               mem[beat_idx][i*8 +: 8] <= dout[i*8 +: 8];
            end
         end
      end
      if (ram_re) begin
         ram_rdata_q <= mem[beat_idx];
      end
   end

endmodule
